// File: rtl/tala_pkg.sv
// rtl/tala_pkg.sv - gesture codes, anga/tala/jati encodings and sequence lookups
package tala_pkg;

  localparam logic [1:0] LED_OFF    = 2'b00;
  localparam logic [1:0] LED_CLAP   = 2'b01;
  localparam logic [1:0] LED_WAVE   = 2'b10;
  localparam logic [1:0] LED_FINGER = 2'b11;

  typedef enum logic [1:0] {ANGA_L, ANGA_D, ANGA_A, ANGA_NONE} anga_e;

  localparam logic [2:0] TALA_DHRUVA  = 3'd0;
  localparam logic [2:0] TALA_MATYA   = 3'd1;
  localparam logic [2:0] TALA_RUPAKA  = 3'd2;
  localparam logic [2:0] TALA_JHAMPA  = 3'd3;
  localparam logic [2:0] TALA_TRIPUTA = 3'd4;
  localparam logic [2:0] TALA_ATA     = 3'd5;
  localparam logic [2:0] TALA_EKA     = 3'd6;

  localparam logic [2:0] JATI_TISRA     = 3'd0;
  localparam logic [2:0] JATI_CHATUSRA  = 3'd1;
  localparam logic [2:0] JATI_KHANDA    = 3'd2;
  localparam logic [2:0] JATI_MISRA     = 3'd3;
  localparam logic [2:0] JATI_SANKEERNA = 3'd4;

  localparam int MAX_BEATS = 29;

  // Sequences are packed last-anga-first so anga idx selects bits [2*idx +: 2].
  function automatic anga_e anga_at(input logic [2:0] tala, input logic [1:0] idx);
    logic [7:0] seq;
    case (tala)
      TALA_DHRUVA: seq = {ANGA_L,    ANGA_L,    ANGA_D,    ANGA_L};
      TALA_MATYA:  seq = {ANGA_NONE, ANGA_L,    ANGA_D,    ANGA_L};
      TALA_RUPAKA: seq = {ANGA_NONE, ANGA_NONE, ANGA_L,    ANGA_D};
      TALA_JHAMPA: seq = {ANGA_NONE, ANGA_D,    ANGA_A,    ANGA_L};
      TALA_ATA:    seq = {ANGA_D,    ANGA_D,    ANGA_L,    ANGA_L};
      TALA_EKA:    seq = {ANGA_NONE, ANGA_NONE, ANGA_NONE, ANGA_L};
      default:     seq = {ANGA_NONE, ANGA_D,    ANGA_D,    ANGA_L};
    endcase
    return anga_e'(seq[{idx, 1'b0} +: 2]);
  endfunction

  function automatic logic [3:0] jati_len(input logic [2:0] jati);
    case (jati)
      JATI_TISRA:     return 4'd3;
      JATI_KHANDA:    return 4'd5;
      JATI_MISRA:     return 4'd7;
      JATI_SANKEERNA: return 4'd9;
      default:        return 4'd4;
    endcase
  endfunction

endpackage

// File: rtl/tala_sequencer_if.sv
// rtl/tala_sequencer_if.sv - control inputs and gesture/pulse outputs of the sequencer
interface tala_sequencer_if #(
  parameter int CYC_W = 10
);
  logic             en;
  logic [1:0]       speed_sel;
  logic [2:0]       tala_sel;
  logic [2:0]       jati_sel;
  logic [1:0]       led;
  logic [4:0]       beat_idx;
  logic             beat_pulse;
  logic             cycle_pulse;
  logic [CYC_W-1:0] cycle_count;

  modport master (
    output en, speed_sel, tala_sel, jati_sel,
    input  led, beat_idx, beat_pulse, cycle_pulse, cycle_count
  );

  modport slave (
    input  en, speed_sel, tala_sel, jati_sel,
    output led, beat_idx, beat_pulse, cycle_pulse, cycle_count
  );
endinterface

// File: rtl/tala_beat_timer.sv
// rtl/tala_beat_timer.sv - intra-beat tick counter with per-beat latched period
module tala_beat_timer #(
  parameter int unsigned P_SLOW = 10,
  parameter int unsigned P_MED  = 6,
  parameter int unsigned P_FAST = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       speed_sel,
  output logic [CNT_W-1:0] tick,
  output logic [CNT_W-1:0] period,
  output logic             beat_end
);

  function automatic logic [CNT_W-1:0] period_of(input logic [1:0] sel);
    case (sel)
      2'b01:   return CNT_W'(P_MED);
      2'b10:   return CNT_W'(P_FAST);
      default: return CNT_W'(P_SLOW);
    endcase
  endfunction

  assign beat_end = en && (tick == period - CNT_W'(1));

  // Speed only takes effect at a beat boundary so a beat never changes length mid-way.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick   <= '0;
      period <= period_of(speed_sel);
    end else if (beat_end) begin
      tick   <= '0;
      period <= period_of(speed_sel);
    end else if (en) begin
      tick   <= tick + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tala_sequencer.sv
// rtl/tala_sequencer.sv - suladi tala gesture sequencer for any tala, jati and speed
module tala_sequencer
  import tala_pkg::*;
#(
  parameter int unsigned P_SLOW = 10,
  parameter int unsigned P_MED  = 6,
  parameter int unsigned P_FAST = 4,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned CYC_W  = 10
) (
  input logic              clk,
  input logic              rst,
  tala_sequencer_if.slave  bus
);

  logic [CNT_W-1:0] tick;
  logic [CNT_W-1:0] period;
  logic             beat_end;

  logic [2:0]       tala_q;
  logic [2:0]       jati_q;
  logic [1:0]       anga_idx;
  logic [3:0]       pos;
  logic [4:0]       beat_idx_q;
  logic [CYC_W-1:0] cycle_count_q;

  anga_e            cur_anga;
  logic [3:0]       anga_len;
  logic             anga_last;
  logic             tala_last;
  logic             cycle_end;
  logic [1:0]       gesture;
  logic             lit;

  tala_beat_timer #(
    .P_SLOW (P_SLOW),
    .P_MED  (P_MED),
    .P_FAST (P_FAST),
    .CNT_W  (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .speed_sel (bus.speed_sel),
    .tick      (tick),
    .period    (period),
    .beat_end  (beat_end)
  );

  always_comb begin
    cur_anga = anga_at(tala_q, anga_idx);
    case (cur_anga)
      ANGA_L:  anga_len = jati_len(jati_q);
      ANGA_D:  anga_len = 4'd2;
      default: anga_len = 4'd1;
    endcase
    anga_last = (pos == anga_len - 4'd1);
    tala_last = (anga_idx == 2'd3) || (anga_at(tala_q, anga_idx + 2'd1) == ANGA_NONE);
    cycle_end = beat_end && anga_last && tala_last;

    if (pos == 4'd0)            gesture = LED_CLAP;
    else if (cur_anga == ANGA_L) gesture = LED_FINGER;
    else                         gesture = LED_WAVE;
    lit = (tick < (period >> 1));
  end

  assign bus.led         = (bus.en && lit) ? gesture : LED_OFF;
  assign bus.beat_idx    = beat_idx_q;
  assign bus.beat_pulse  = beat_end;
  assign bus.cycle_pulse = cycle_end;
  assign bus.cycle_count = cycle_count_q;

  // Tala and jati are only sampled at cycle boundaries; mid-cycle edits wait their turn.
  always_ff @(posedge clk) begin
    if (rst) begin
      tala_q        <= bus.tala_sel;
      jati_q        <= bus.jati_sel;
      anga_idx      <= '0;
      pos           <= '0;
      beat_idx_q    <= '0;
      cycle_count_q <= '0;
    end else if (beat_end) begin
      if (!anga_last) begin
        pos        <= pos + 4'd1;
        beat_idx_q <= beat_idx_q + 5'd1;
      end else if (!tala_last) begin
        pos        <= '0;
        anga_idx   <= anga_idx + 2'd1;
        beat_idx_q <= beat_idx_q + 5'd1;
      end else begin
        pos           <= '0;
        anga_idx      <= '0;
        beat_idx_q    <= '0;
        cycle_count_q <= cycle_count_q + CYC_W'(1);
        tala_q        <= bus.tala_sel;
        jati_q        <= bus.jati_sel;
      end
    end
  end

endmodule

// File: tb/tb_tala_sequencer.sv
// tb/tb_tala_sequencer.sv - scoreboard and table-driven bench for tala_sequencer
module tb_tala_sequencer;

  localparam int CYC_W = 10;

  typedef struct packed {
    logic [1:0]       led;
    logic [4:0]       bi;
    logic             bp;
    logic             cp;
    logic [CYC_W-1:0] cc;
  } obs_t;

  typedef struct {
    logic [2:0] t;
    logic [2:0] j;
    logic [1:0] s;
    int         clocks;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tala_sequencer_if #(.CYC_W(CYC_W)) bus ();

  tala_sequencer #(
    .P_SLOW (10),
    .P_MED  (6),
    .P_FAST (4),
    .CNT_W  (8),
    .CYC_W  (CYC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  obs_t sb[$];
  obs_t obs;

  int         m_tick, m_p, m_beat, m_len, m_cc;
  logic [1:0] m_seq[0:31];

  function automatic int per_of(input logic [1:0] s);
    return (s == 2'b01) ? 6 : (s == 2'b10) ? 4 : 10;
  endfunction

  task automatic build(input logic [2:0] t, input logic [2:0] j);
    string s;
    int    jl;
    byte   c;
    case (t)
      3'd0: s = "LDLL";
      3'd1: s = "LDL";
      3'd2: s = "DL";
      3'd3: s = "LAD";
      3'd5: s = "LLDD";
      3'd6: s = "L";
      default: s = "LDD";
    endcase
    case (j)
      3'd0: jl = 3;
      3'd2: jl = 5;
      3'd3: jl = 7;
      3'd4: jl = 9;
      default: jl = 4;
    endcase
    m_len = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      m_seq[m_len] = 2'b01;
      m_len++;
      if (c == "L") begin
        for (int k = 1; k < jl; k++) begin
          m_seq[m_len] = 2'b11;
          m_len++;
        end
      end else if (c == "D") begin
        m_seq[m_len] = 2'b10;
        m_len++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // One clock: predict, observe at negedge, compare, then advance the model.
  task automatic tick1();
    obs_t e;
    if (!rst) begin
      e.led = (bus.en && m_tick < m_p / 2) ? m_seq[m_beat] : 2'b00;
      e.bp  = bus.en && (m_tick == m_p - 1);
      e.cp  = e.bp && (m_beat == m_len - 1);
      e.bi  = m_beat[4:0];
      e.cc  = m_cc[CYC_W-1:0];
      sb.push_back(e);
    end
    @(negedge clk);
    obs = {bus.led, bus.beat_idx, bus.beat_pulse, bus.cycle_pulse, bus.cycle_count};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs != e) begin
        failures++;
        $display("FAIL sb t=%0t actual led=%0d bi=%0d bp=%0d cp=%0d cc=%0d required led=%0d bi=%0d bp=%0d cp=%0d cc=%0d",
                 $time, obs.led, obs.bi, obs.bp, obs.cp, obs.cc, e.led, e.bi, e.bp, e.cp, e.cc);
      end
    end
    if (rst) begin
      m_tick = 0; m_beat = 0; m_cc = 0;
      m_p = per_of(bus.speed_sel);
      build(bus.tala_sel, bus.jati_sel);
    end else if (bus.en) begin
      if (m_tick < m_p - 1) m_tick++;
      else begin
        m_tick = 0;
        m_p = per_of(bus.speed_sel);
        if (m_beat == m_len - 1) begin
          m_beat = 0;
          m_cc = (m_cc + 1) % (1 << CYC_W);
          build(bus.tala_sel, bus.jati_sel);
        end else m_beat++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] t, input logic [2:0] j, input logic [1:0] s);
    rst = 1'b1;
    bus.en = 1'b1;
    bus.tala_sel = t;
    bus.jati_sel = j;
    bus.speed_sel = s;
    tick1();
    rst = 1'b0;
  endtask

  task automatic run_until(input bit cyc, input int max, output int n);
    n = 0;
    do begin
      tick1();
      n++;
    end while (!(cyc ? obs.cp : obs.bp) && n < max);
    if (!(cyc ? obs.cp : obs.bp)) begin
      checks++;
      failures++;
      $display("FAIL timeout cyc=%0d actual=no pulse required=pulse within %0d", cyc, max);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  vec_t vt[8];
  int   adi_led[8];
  int   rup_led[5];
  int   n;

  initial begin
    vt[0] = '{3'd4, 3'd1, 2'd0, 80};
    vt[1] = '{3'd2, 3'd0, 2'd2, 20};
    vt[2] = '{3'd0, 3'd4, 2'd1, 174};
    vt[3] = '{3'd6, 3'd3, 2'd2, 28};
    vt[4] = '{3'd3, 3'd2, 2'd3, 80};
    vt[5] = '{3'd5, 3'd1, 2'd2, 48};
    vt[6] = '{3'd1, 3'd0, 2'd1, 48};
    vt[7] = '{3'd7, 3'd6, 2'd0, 80};
    adi_led = '{1, 3, 3, 3, 1, 2, 1, 2};
    rup_led = '{1, 2, 1, 3, 3};
    rst = 1'b1;
    bus.en = 1'b0;
    bus.speed_sel = 2'd0;
    bus.tala_sel = 3'd0;
    bus.jati_sel = 3'd0;

    // Adi: reset state, per-beat gesture and lit window
    do_reset(3'd4, 3'd1, 2'd0);
    for (int b = 0; b < 8; b++) begin
      tick1();
      if (b == 0) begin
        chk("rst_bi", obs.bi, 0);
        chk("rst_cc", obs.cc, 0);
        chk("rst_pulses", {obs.bp, obs.cp}, 0);
      end
      chk($sformatf("adi_led_b%0d", b), obs.led, adi_led[b]);
      repeat (4) tick1();
      chk($sformatf("adi_lit_end_b%0d", b), obs.led, adi_led[b]);
      tick1();
      chk($sformatf("adi_dark_b%0d", b), obs.led, 0);
      repeat (4) tick1();
    end
    chk("adi_cp80", obs.cp, 1);
    tick1();
    chk("adi_cc1", obs.cc, 1);

    // Rupaka tisra fast
    do_reset(3'd2, 3'd0, 2'd2);
    for (int b = 0; b < 5; b++) begin
      tick1();
      chk($sformatf("rup_led_b%0d", b), obs.led, rup_led[b]);
      repeat (3) tick1();
    end
    chk("rup_cp20", obs.cp, 1);

    for (int i = 0; i < 8; i++) begin
      do_reset(vt[i].t, vt[i].j, vt[i].s);
      run_until(1'b1, 400, n);
      chk($sformatf("cyc_len_%0d", i), n, vt[i].clocks);
      run_until(1'b1, 400, n);
      chk($sformatf("cyc_len2_%0d", i), n, vt[i].clocks);
    end

    // Tala/jati change mid-cycle waits for the cycle end
    do_reset(3'd4, 3'd1, 2'd0);
    repeat (25) tick1();
    bus.tala_sel = 3'd6;
    bus.jati_sel = 3'd3;
    run_until(1'b1, 400, n);
    chk("cfg_adi_rest", n, 55);
    run_until(1'b1, 400, n);
    chk("cfg_eka_misra", n, 70);

    // Speed change mid-beat
    do_reset(3'd4, 3'd1, 2'd0);
    repeat (4) tick1();
    bus.speed_sel = 2'd1;
    run_until(1'b0, 40, n);
    chk("spd_cur_beat", n, 6);
    run_until(1'b0, 40, n);
    chk("spd_next_beat", n, 6);

    // Enable gap mid-beat
    do_reset(3'd4, 3'd1, 2'd0);
    repeat (33) tick1();
    bus.en = 1'b0;
    repeat (13) tick1();
    chk("gap_led", obs.led, 0);
    chk("gap_bi", obs.bi, 3);
    bus.en = 1'b1;
    run_until(1'b1, 400, n);
    chk("gap_resume", n, 47);

    // Reset while disabled, mid-cycle; 7/6 must act as Triputa chatusra
    repeat (20) tick1();
    bus.en = 1'b0;
    rst = 1'b1;
    bus.tala_sel = 3'd7;
    bus.jati_sel = 3'd6;
    tick1();
    rst = 1'b0;
    bus.en = 1'b1;
    tick1();
    chk("rst2_bi", obs.bi, 0);
    chk("rst2_led", obs.led, 1);
    chk("rst2_cc", obs.cc, 0);
    run_until(1'b1, 400, n);
    chk("rst2_len", n, 79);

    // cycle_count wrap with the shortest cycle (Eka tisra fast, 12 clocks)
    do_reset(3'd6, 3'd0, 2'd2);
    repeat (1024 * 12) tick1();
    chk("wrap_pre", obs.cc, 1023);
    tick1();
    chk("wrap_zero", obs.cc, 0);

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tala_sequencer.md
Name: tala_sequencer

Overview:
- Parametrised successor of the fixed Adi tala LED generator. Plays any of the seven suladi talas in any of five jatis at a selectable speed.
- Drives a 2-bit gesture output (clap / wave / finger count) plus beat index, beat and cycle pulses, and a cycle counter.
- Sits between the board clock and the LED / pulse consumers. Single clock domain.

Parameters:
- P_SLOW, 10, clocks per beat for speed_sel 00 and 11.
- P_MED, 6, clocks per beat for speed_sel 01.
- P_FAST, 4, clocks per beat for speed_sel 10.
- CNT_W, 8, width of the intra-beat tick counter. Every P_* value must be ≥2 and < 2^CNT_W.
- CYC_W, 10, width of cycle_count.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- en, input, 1, run enable; 0 freezes all state.
- speed_sel, input, 2, speed select.
- tala_sel, input, 3, 0 Dhruva, 1 Matya, 2 Rupaka, 3 Jhampa, 4 Triputa, 5 Ata, 6 Eka, 7 = Triputa.
- jati_sel, input, 3, 0 tisra (3), 1 chatusra (4), 2 khanda (5), 3 misra (7), 4 sankeerna (9), 5-7 = chatusra.
- led, output, 2, gesture: 00 off, 01 clap, 10 wave, 11 finger count.
- beat_idx, output, 5, beat number within the cycle, 0..len-1.
- beat_pulse, output, 1, high for one clock on the last tick of every beat.
- cycle_pulse, output, 1, high for one clock on the last tick of the last beat.
- cycle_count, output, CYC_W, completed cycles; wraps to 0.

Behaviour:
- Anga sequences (L laghu, D drutam, A anudrutam):
  - Dhruva: L D L L
  - Matya: L D L
  - Rupaka: D L
  - Jhampa: L A D
  - Triputa: L D D
  - Ata: L L D D
  - Eka: L
- Anga gestures:
  - Laghu = clap, then (jati-1) finger counts.
  - Drutam = clap, wave.
  - Anudrutam = clap.
- Maximum cycle length is 29 beats (Dhruva sankeerna), so beat_idx is 5 bits.
- State registers:
  - tick counter (CNT_W)
  - anga index (0..3)
  - position within anga (0..8)
  - beat_idx
  - latched tala, jati and period (P)
  - cycle_count
- Reset (rst=1 at a clock edge): all counters 0, anga index 0, position 0, cycle_count 0. tala/jati/P are latched from the current inputs. rst has priority over en.
- Config latching:
  - tala_sel and jati_sel are latched only at reset and at the edge that ends a cycle.
  - speed_sel is latched at reset and at every beat end.
  - Mid-beat or mid-cycle input changes have no effect until that boundary.
- Per clock with en=1:
  - If tick < P-1: tick increments.
  - Otherwise: tick goes to 0, beat_pulse=1, and the beat advances. The position advances; at the anga end, position returns to 0 and the anga index advances. At the last anga end, the anga index and beat_idx go to 0, cycle_pulse=1, cycle_count increments, and config is relatched.
- en=0: all registers hold, led=00, beat_pulse=0, cycle_pulse=0.
- led is a combinational decode of registers and en:
  - It equals the current beat's gesture while tick < floor(P/2), else 00.
  - No combinational path from speed_sel, tala_sel or jati_sel to any output.
- beat_pulse and cycle_pulse are combinational from the registered tick/position state and en. They are asserted in the same clock as the final tick.
- cycle_count wraps from 2^CYC_W-1 to 0 without a flag.
- Reset outputs (the clock after rst with en=1): led = 01 (first beat is always a clap), beat_idx 0, both pulses 0, cycle_count 0.

Decomposition:
- Package tala_pkg holds:
  - gesture codes LED_OFF/CLAP/WAVE/FINGER
  - anga enum {ANGA_L, ANGA_D, ANGA_A, ANGA_NONE}
  - tala and jati encodings
  - MAX_BEATS=29
  - function anga_at(tala, idx) returning the anga or NONE past the end
  - function jati_len(jati)
- One sub-module, tala_beat_timer: tick counter, period mux from speed_sel, and the beat-end strobe.

Test Plan:
- Reset, en=1, tala=4, jati=1, speed=00 (Adi):
  - led per beat is 01,11,11,11,01,10,01,10; each beat is lit for 5 clocks then off for 5.
  - cycle_pulse appears at clock 80; cycle_count=1 after it.
- Rupaka tisra, speed=10:
  - Beat length is 4 clocks with 2 lit; sequence 01,10,01,11,11.
  - cycle_pulse every 20 clocks.
- Change tala_sel 4→6 and jati_sel 1→3 at beat 2 of an Adi cycle:
  - The Adi cycle completes unchanged.
  - The next cycle is Eka misra: 7 beats, clap then 6 finger counts.
- Toggle speed_sel 00→01 mid-beat:
  - The current beat finishes its 10 clocks; the following beats are 6 clocks with 3 lit.
- Drop en for 13 clocks mid-beat:
  - led=00 and no pulses during the gap; tick and beat resume exactly where they stopped.
- Assert rst mid-cycle with en=1 (including while en=0):
  - The next clock has beat_idx=0, led=01 and cycle_count=0.
  - tala_sel=7 and jati_sel=6 behave as Triputa chatusra.
